ahb3lite_sram_slave: RTL
========================

// Module: ahb3lite_sram_slave
// PURPOSE
//  AHB-Lite responder: word-addressed SRAM slave answering single and burst (SINGLE/INCR/INCR4/8/16,
//  WRAP4/8/16) transfers from the bus master. Terminates the master-side burst tests on the shared bus.
//  Handles byte/half/word writes, reads, IDLE/BUSY, two-cycle ERROR, and read-after-write forwarding.
// PARAMETERS
//  HADDR_SIZE   32   address width
//  HDATA_SIZE   32   data width (byte lanes = HDATA_SIZE/8)
//  MEM_DEPTH    256  number of HDATA_SIZE words; legal byte range 0 .. MEM_DEPTH*HDATA_SIZE/8-1
//  WAIT_CYCLES  2    wait states on first beat of each NONSEQ (used only with AHB_SLV_WAIT_STATES_EN)
// PORTS
//  HCLK       in   1           clock
//  HRESET     in   1           reset, synchronous, active-high
//  HSEL       in   1           slave select
//  HADDR      in   HADDR_SIZE  address phase address
//  HWRITE     in   1           1=write
//  HSIZE      in   3           transfer size
//  HBURST     in   3           burst type (accepted, not checked)
//  HPROT      in   4           protection (ignored)
//  HTRANS     in   2           IDLE/BUSY/NONSEQ/SEQ
//  HMASTLOCK  in   1           ignored
//  HREADY     in   1           bus ready (previous data phase complete)
//  HWDATA     in   HDATA_SIZE  write data (data phase)
//  HREADYOUT  out  1           slave ready
//  HRESP      out  1           0=OKAY, 1=ERROR
//  HRDATA     out  HDATA_SIZE  read data (data phase)
// BEHAVIOUR
//  Reset: HREADYOUT=1, HRESP=0, HRDATA=0, FSM=IDLE, pending-write cleared; RAM contents kept.
//  Reset mid-burst: aborts in-flight beat; its pending write is discarded.
//  Accept: HSEL & HREADY & HTRANS[1] at posedge -> register addr/size/write; data phase next cycle.
//  IDLE/BUSY or !HSEL: OKAY, zero wait, no RAM access.
//  Error if addr >= MEM_DEPTH*bytes, HSIZE > log2(bytes), or addr misaligned to HSIZE:
//   cycle1 HREADYOUT=0 HRESP=1; cycle2 HREADYOUT=1 HRESP=1; no RAM access; next accept in cycle2.
//  FSM: IDLE -> ACCESS (legal accept) | ERR1 (illegal); ACCESS -> ACCESS/ERR1/IDLE per next accept;
//   ERR1 -> ERR2; ERR2 -> ACCESS/ERR1/IDLE; WAIT (macro only) -> ACCESS when counter hits 0.
//  Write: byte enables from HSIZE/HADDR low bits (little-endian); HWDATA written at edge ending data phase.
//  Read: RAM is synchronous-read, addressed at accept edge; HRDATA valid in data phase, zero wait.
//  Forwarding: read accept at same edge as pending write to same word -> HRDATA merges written byte lanes.
//  HRDATA holds last read value on writes/idle; unused lanes return RAM contents.
// CONFIGURATION
//  AHB_SLV_WAIT_STATES_EN defined: NONSEQ beats enter WAIT, HREADYOUT=0 for WAIT_CYCLES cycles,
//   SEQ beats zero wait; WAIT_CYCLES=0 behaves as undefined. Undefined: every OKAY beat zero wait, no WAIT state.
// STRUCTURE
//  ahb3lite_pkg: htrans_t (IDLE/BUSY/NONSEQ/SEQ), hburst_t, hsize_t, HRESP_OKAY/HRESP_ERROR, FSM state enum.
//  Sub-module ahb_slv_mem: MEM_DEPTH x HDATA_SIZE sync-read RAM with per-byte write enables.
// TESTING
//  INCR4 word writes 0x1111_1111..0x4444_4444 to 0x0/0x4/0x8/0xC, INCR4 reads -> same data, HRESP=0, zero wait.
//  Byte write HSIZE=0 addr 0x5 HWDATA=0x0000_AB00 over 0x2222_2222 -> read 0x4 gives 0x2222_AB22.
//  Write 0xDEAD_BEEF to 0x10 then immediate read 0x10 (back-to-back) -> HRDATA=0xDEAD_BEEF via forwarding.
//  Access addr 0x400 (MEM_DEPTH=256) -> HREADYOUT 0 then 1 with HRESP=1 both cycles; RAM unchanged.
//  HRESET asserted during beat 2 of INCR4 write -> outputs reset values next cycle; word 0x4 unmodified.
//  With AHB_SLV_WAIT_STATES_EN, WAIT_CYCLES=2: INCR4 read -> 2 low HREADYOUT cycles on beat 0 only.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite types and constants for the SRAM slave: transfer/burst/size
// encodings, response codes and the slave FSM state enum.
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HALF  = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2,
        ST_WAIT
    } slv_state_t;

endpackage

// File: rtl/ahb_slv_mem.sv
// Synchronous-read single-port-style RAM with per-byte write enables.
// Read-before-write on a same-word collision; only the read register is reset.
module ahb_slv_mem #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH/8-1:0]         be,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto RAM macros; contents survive HRESET.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH / 8; i++) begin
            if (we && be[i]) begin
                mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB-Lite SRAM responder with two-cycle ERROR and read-after-write forwarding.
// Optional NONSEQ wait states when AHB_SLV_WAIT_STATES_EN is defined.
module ahb3lite_sram_slave
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE  = 32,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [HDATA_SIZE-1:0] HRDATA
);

    localparam int BYTES    = HDATA_SIZE / 8;
    localparam int ADDR_LSB = $clog2(BYTES);
    localparam int AW       = $clog2(MEM_DEPTH);
    localparam logic [HADDR_SIZE-1:0] ADDR_LIMIT = HADDR_SIZE'(MEM_DEPTH * BYTES);

    slv_state_t state, state_next;

    logic                  accept, legal, pending, mem_we, mem_re, fwd_hit;
    logic [ADDR_LSB-1:0]   align_mask;
    logic [ADDR_LSB-1:0]   addr_lo_q;
    logic [AW-1:0]         word_q;
    logic [2:0]            size_q;
    logic                  write_q;
    logic [BYTES-1:0]      wr_be, fwd_mask;
    logic [HDATA_SIZE-1:0] fwd_data, mem_rdata;

    wire unused_ok = &{1'b0, HBURST, HPROT, HMASTLOCK, HTRANS[0], (WAIT_CYCLES != 0)};

    assign accept     = HSEL && HREADY && HTRANS[1];
    assign align_mask = ~({ADDR_LSB{1'b1}} << HSIZE);
    assign legal      = (HADDR < ADDR_LIMIT) && (HSIZE <= 3'(ADDR_LSB))
                     && ((HADDR[ADDR_LSB-1:0] & align_mask) == '0);

    assign pending = (state == ST_ACCESS) && write_q;
    assign mem_we  = pending && HREADY && !HRESET;
    assign mem_re  = accept && legal && !HWRITE;
    // A read accepted on the edge that retires a write to the same word sees stale RAM data.
    assign fwd_hit = mem_re && pending && HREADY && (HADDR[ADDR_LSB +: AW] == word_q);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            write_q   <= 1'b0;
            addr_lo_q <= '0;
            word_q    <= '0;
            size_q    <= '0;
        end else if (accept) begin
            write_q   <= HWRITE;
            addr_lo_q <= HADDR[ADDR_LSB-1:0];
            word_q    <= HADDR[ADDR_LSB +: AW];
            size_q    <= HSIZE;
        end
    end

    // Little-endian lanes: lane i is enabled when it shares the size-aligned block with the address.
    always_comb begin
        wr_be = '0;
        for (int i = 0; i < BYTES; i++) begin
            wr_be[i] = ((i ^ int'(addr_lo_q)) >> size_q) == 0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            fwd_mask <= '0;
        end else if (mem_re) begin
            fwd_mask <= fwd_hit ? wr_be : '0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (mem_re) begin
            fwd_data <= HWDATA;
        end
    end

    ahb_slv_mem #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (HDATA_SIZE)
    ) u_mem (
        .clk   (HCLK),
        .rst   (HRESET),
        .re    (mem_re),
        .raddr (HADDR[ADDR_LSB +: AW]),
        .we    (mem_we),
        .waddr (word_q),
        .be    (wr_be),
        .wdata (HWDATA),
        .rdata (mem_rdata)
    );

    always_comb begin
        HRDATA = mem_rdata;
        for (int i = 0; i < BYTES; i++) begin
            if (fwd_mask[i]) begin
                HRDATA[i*8 +: 8] = fwd_data[i*8 +: 8];
            end
        end
    end

`ifdef AHB_SLV_WAIT_STATES_EN
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wait_cnt <= '0;
        end else if (state != ST_WAIT && state_next == ST_WAIT) begin
            wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
        end else if (state == ST_WAIT && wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end
`endif

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next gets a default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_ERR1: state_next = ST_ERR2;
`ifdef AHB_SLV_WAIT_STATES_EN
            ST_WAIT: if (wait_cnt == '0) state_next = ST_ACCESS;
`endif
            default: begin
                if (HREADY) begin
                    if (!accept) begin
                        state_next = ST_IDLE;
                    end else if (!legal) begin
                        state_next = ST_ERR1;
`ifdef AHB_SLV_WAIT_STATES_EN
                    end else if (HTRANS == HTRANS_NONSEQ && WAIT_CYCLES > 0) begin
                        state_next = ST_WAIT;
`endif
                    end else begin
                        state_next = ST_ACCESS;
                    end
                end
            end
        endcase
    end

    assign HREADYOUT = !(state == ST_ERR1 || state == ST_WAIT);
    assign HRESP     = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

endmodule
